// File: rtl/alu_seq.sv
// alu_seq: single-issue sequencer that feeds the 16-bit combinational ALU from a small register file.
// Optional feature macro: ALU_SEQ_IMM_EN (instr_imm replaces operand B when instr_imm_en is set).
module alu_seq #(
    parameter int NUM_REGS = 8,
    localparam int RA_W = $clog2(NUM_REGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [3:0]      instr_op,
    input  logic [RA_W-1:0] instr_rd,
    input  logic [RA_W-1:0] instr_rs1,
    input  logic [RA_W-1:0] instr_rs2,
    input  logic            instr_imm_en,
    input  logic [15:0]     instr_imm,
    output logic [15:0]     alu_a,
    output logic [15:0]     alu_b,
    output logic [3:0]      alu_op,
    input  logic [15:0]     alu_result,
    input  logic            alu_zero,
    input  logic            alu_carry,
    input  logic            alu_overflow,
    output logic            wb_valid,
    output logic [RA_W-1:0] wb_rd,
    output logic [15:0]     wb_data,
    output logic [2:0]      flags,
    output logic            busy,
    input  logic [RA_W-1:0] dbg_raddr,
    output logic [15:0]     dbg_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    state_t          state;
    logic [15:0]     regs [NUM_REGS];
    logic [RA_W-1:0] rd_q;
    logic [15:0]     src_a;
    logic [15:0]     src_b;
    logic [15:0]     src_rs2;
    logic            op_defined;

    // Register 0 is hardwired to zero on every read port.
    assign src_a     = (instr_rs1 == '0) ? 16'h0000 : regs[instr_rs1];
    assign src_rs2   = (instr_rs2 == '0) ? 16'h0000 : regs[instr_rs2];
    assign dbg_rdata = (dbg_raddr == '0) ? 16'h0000 : regs[dbg_raddr];

`ifdef ALU_SEQ_IMM_EN
    assign src_b = instr_imm_en ? instr_imm : src_rs2;
`else
    logic unused_imm;
    assign unused_imm = ^{instr_imm_en, instr_imm};
    assign src_b      = src_rs2;
`endif

    assign op_defined  = (alu_op < 4'd12);
    assign instr_ready = (state == IDLE);
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            alu_a    <= 16'h0000;
            alu_b    <= 16'h0000;
            alu_op   <= 4'h0;
            rd_q     <= '0;
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= 16'h0000;
            flags    <= 3'b000;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= 16'h0000;
            end
        end else begin
            wb_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        alu_a  <= src_a;
                        alu_b  <= src_b;
                        alu_op <= instr_op;
                        rd_q   <= instr_rd;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // Undefined op codes retire silently: no write, no flags, no strobe.
                    if (op_defined) begin
                        if (rd_q != '0) begin
                            regs[rd_q] <= alu_result;
                        end
                        flags    <= {alu_overflow, alu_carry, alu_zero};
                        wb_rd    <= rd_q;
                        wb_data  <= alu_result;
                        wb_valid <= 1'b1;
                        state    <= WB;
                    end else begin
                        state <= IDLE;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
